// File: rtl/aes_pkg.sv
// Shared AES-128 round-datapath definitions: widths, byte indexing, beat payload
// and skid-buffer state encoding.
package aes_pkg;

    localparam int unsigned AES_STATE_W    = 128;
    localparam int unsigned AES_NUM_ROUNDS = 10;
    localparam int unsigned AES_ROUND_W    = 4;

    // Byte 0 sits in the MSBs (FIPS-197 column-major order)
    localparam int unsigned AES_BYTE_W     = 8;
    localparam int unsigned AES_NUM_BYTES  = AES_STATE_W / AES_BYTE_W;
    localparam int unsigned AES_BYTE0_LSB  = AES_STATE_W - AES_BYTE_W;

    function automatic int unsigned aes_byte_lsb(input int unsigned idx);
        return (AES_NUM_BYTES - 1 - idx) * AES_BYTE_W;
    endfunction

    typedef struct packed {
        logic [AES_STATE_W-1:0] state;
        logic [AES_ROUND_W-1:0] round;
        logic                   last;
    } ark_beat_t;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/add_round_key_stage_if.sv
// Upstream/downstream handshake bundle of the AddRoundKey stage.
interface add_round_key_stage_if;

    logic                               in_valid;
    logic                               in_ready;
    logic [aes_pkg::AES_STATE_W-1:0]    in_state;
    logic [aes_pkg::AES_STATE_W-1:0]    in_key;
    logic [aes_pkg::AES_ROUND_W-1:0]    in_round;
    logic                               out_valid;
    logic                               out_ready;
    logic [aes_pkg::AES_STATE_W-1:0]    out_state;
    logic [aes_pkg::AES_ROUND_W-1:0]    out_round;
    logic                               out_last;
    logic                               err_round;

    modport master (
        output in_valid, in_state, in_key, in_round, out_ready,
        input  in_ready, out_valid, out_state, out_round, out_last, err_round
    );

    modport slave (
        input  in_valid, in_state, in_key, in_round, out_ready,
        output in_ready, out_valid, out_state, out_round, out_last, err_round
    );

endinterface

// File: rtl/ark_skid_buf.sv
// Generic 2-entry skid buffer (main + skid register); only built when ARK_SKID_EN
// is defined. in_ready_o is registered and low only while both entries are full.
`ifdef ARK_SKID_EN
module ark_skid_buf
    import aes_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o
);

    skid_state_e       state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              valid_q, in_ready_q;
    logic              accept_c, emit_c;

    assign accept_c = in_valid_i && in_ready_q;
    assign emit_c   = valid_q && out_ready_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            SKID_EMPTY: begin
                if (accept_c) begin
                    main_d  = in_data_i;
                    state_d = SKID_ONE;
                end
            end
            SKID_ONE: begin
                if (accept_c && emit_c) begin
                    main_d = in_data_i;
                end else if (accept_c) begin
                    skid_d  = in_data_i;
                    state_d = SKID_FULL;
                end else if (emit_c) begin
                    state_d = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                if (emit_c) begin
                    main_d  = skid_q;
                    state_d = SKID_ONE;
                end
            end
            default: state_d = SKID_EMPTY;
        endcase
    end

    // Flags are registered from the next state so both handshake outputs come off flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= SKID_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            valid_q    <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            valid_q    <= (state_d != SKID_EMPTY);
            in_ready_q <= (state_d != SKID_FULL);
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = valid_q;
    assign out_data_o  = main_q;

endmodule
`endif

// File: rtl/add_round_key_stage.sv
// Registered AddRoundKey stage feeding sub_bytes. Define ARK_SKID_EN for the
// 2-entry skid buffer with registered in_ready; otherwise a single output register.
module add_round_key_stage
    import aes_pkg::*;
#(
    parameter int unsigned STATE_W    = AES_STATE_W,
    parameter int unsigned NUM_ROUNDS = AES_NUM_ROUNDS
) (
    input  logic                 clk,
    input  logic                 rst,
    add_round_key_stage_if.slave bus
);

    localparam logic [AES_ROUND_W-1:0] LAST_ROUND = AES_ROUND_W'(NUM_ROUNDS);

    logic [STATE_W-1:0] keyed_c;
    ark_beat_t          beat_c;
    ark_beat_t          out_beat;
    logic               in_ready_c;
    logic               accept_c;
    logic               out_valid_c;
    logic               err_q, err_d;

    assign keyed_c  = bus.in_state ^ bus.in_key;
    assign accept_c = bus.in_valid && in_ready_c;

    always_comb begin
        beat_c       = '0;
        beat_c.state = keyed_c;
        beat_c.round = bus.in_round;
        beat_c.last  = (bus.in_round == LAST_ROUND);
    end

    // Out-of-range round indices still pass through; the error flag is sticky until reset
    assign err_d = err_q || (accept_c && (bus.in_round > LAST_ROUND));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

`ifdef ARK_SKID_EN
    logic [$bits(ark_beat_t)-1:0] skid_out;

    ark_skid_buf #(
        .DATA_W ($bits(ark_beat_t))
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (bus.in_valid),
        .in_ready_o  (in_ready_c),
        .in_data_i   (beat_c),
        .out_valid_o (out_valid_c),
        .out_ready_i (bus.out_ready),
        .out_data_o  (skid_out)
    );

    assign out_beat = ark_beat_t'(skid_out);
`else
    ark_beat_t out_q, out_d;
    logic      out_valid_q, out_valid_d;

    // Ready whenever the register is empty or is being drained this cycle
    assign in_ready_c = !out_valid_q || bus.out_ready;

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (accept_c) begin
            out_d       = beat_c;
            out_valid_d = 1'b1;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid_c = out_valid_q;
    assign out_beat    = out_q;
`endif

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_state = out_beat.state;
    assign bus.out_round = out_beat.round;
    assign bus.out_last  = out_beat.last;
    assign bus.err_round = err_q;

endmodule

// File: tb/tb_add_round_key_stage.sv
// Directed self-checking bench for add_round_key_stage (either buffering scheme).
module tb_add_round_key_stage;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    add_round_key_stage_if bus ();

    add_round_key_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [131:0] obs, input logic [131:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [127:0] s, input logic [127:0] k,
                         input logic [3:0] r);
        bus.in_valid = v;
        bus.in_state = s;
        bus.in_key   = k;
        bus.in_round = r;
    endtask

    task automatic check_out(input string tag, input logic [127:0] s, input logic [3:0] r,
                             input logic l);
        check({tag, ".valid"}, 132'(bus.out_valid), 132'(1'b1));
        check({tag, ".state"}, 132'(bus.out_state), 132'(s));
        check({tag, ".round"}, 132'(bus.out_round), 132'(r));
        check({tag, ".last"},  132'(bus.out_last),  132'(l));
    endtask

    logic [132:0] sb_q[$];
    logic [132:0] exp_beat, prev_out;
    logic         stalled_prev;
    int           nsent, stall_accepts, exp_stall_accepts;
    logic [127:0] bp_state, bp_key;
    logic [3:0]   bp_round;

    initial begin
        rst           = 1'b1;
        bus.out_ready = 1'b0;
        drive(1'b0, '0, '0, '0);
        repeat (2) cyc();

        check("rst.out_valid", 132'(bus.out_valid), 132'(0));
        check("rst.out_state", 132'(bus.out_state), 132'(0));
        check("rst.out_round", 132'(bus.out_round), 132'(0));
        check("rst.out_last",  132'(bus.out_last),  132'(0));
        check("rst.err_round", 132'(bus.err_round), 132'(0));
        check("rst.in_ready",  132'(bus.in_ready),  132'(1));
        rst = 1'b0;
        cyc();

        // Directed single beats with a free-running sink
        bus.out_ready = 1'b1;
        drive(1'b1, 128'h3243f6a8885a308d313198a2e0370734,
                    128'h2b7e151628aed2a6abf7158809cf4f3c, 4'd0);
        cyc();
        check_out("fips_r0", 128'h193de3bea0f4e22b9ac68d2ae9f84808, 4'd0, 1'b0);

        drive(1'b1, 128'h001f0e543c4e08596e221b0b4774311a, '0, 4'd1);
        cyc();
        check_out("zero_key", 128'h001f0e543c4e08596e221b0b4774311a, 4'd1, 1'b0);
        check("zero_key.err", 132'(bus.err_round), 132'(0));

        drive(1'b1, 128'hffffffff000000000000000000000000,
                    128'h0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f, 4'd10);
        cyc();
        check_out("last_r10", 128'hf0f0f0f00f0f0f0f0f0f0f0f0f0f0f0f, 4'd10, 1'b1);
        check("last_r10.err", 132'(bus.err_round), 132'(0));

        drive(1'b1, 128'h0, 128'h0123456789abcdef0123456789abcdef, 4'd12);
        cyc();
        check_out("bad_r12", 128'h0123456789abcdef0123456789abcdef, 4'd12, 1'b0);
        check("bad_r12.err", 132'(bus.err_round), 132'(1));

        drive(1'b1, 128'h1, 128'h2, 4'd3);
        cyc();
        check_out("after_bad", 128'h3, 4'd3, 1'b0);
        check("sticky.err", 132'(bus.err_round), 132'(1));

        // Back-to-back: every cycle must show the next beat in order
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, {16{8'(i * 17)}}, {16{8'hff}}, 4'(i));
            cyc();
            check_out($sformatf("b2b%0d", i), {16{~8'(i * 17)}}, 4'(i), 1'b0);
        end
        drive(1'b0, '0, '0, '0);
        cyc();
        check("b2b.drain", 132'(bus.out_valid), 132'(0));

        // Backpressure: out_ready low for cycles 4..6, scoreboard tracks order
        bp_key        = {16{8'h3c}};
        nsent         = 0;
        stall_accepts = 0;
        stalled_prev  = 1'b0;
        prev_out      = '0;
        for (int c = 0; c < 30; c++) begin
            bus.out_ready = !(c >= 4 && c <= 6);
            bp_state      = {16{8'(nsent + 1)}};
            bp_round      = 4'(nsent % 11);
            drive(nsent < 12, bp_state, bp_key, bp_round);
            #1;
            if (stalled_prev) begin
                check("bp.hold_valid", 132'(bus.out_valid), 132'(1));
                check("bp.hold_data", 132'({bus.out_state, bus.out_round, bus.out_last}),
                      132'(prev_out));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    check("bp.spurious_emit", 132'(1), 132'(0));
                end else begin
                    exp_beat = sb_q.pop_front();
                    check("bp.emit", 132'({bus.out_state, bus.out_round, bus.out_last}),
                          132'(exp_beat));
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                sb_q.push_back({bp_state ^ bp_key, bp_round, bp_round == 4'd10});
                nsent++;
                if (c >= 4 && c <= 6) stall_accepts++;
            end
            stalled_prev = bus.out_valid && !bus.out_ready;
            prev_out     = {bus.out_state, bus.out_round, bus.out_last};
            @(posedge clk);
            #1;
            if (nsent == 12 && sb_q.size() == 0 && !bus.out_valid) break;
        end
`ifdef ARK_SKID_EN
        exp_stall_accepts = 1;
`else
        exp_stall_accepts = 0;
`endif
        check("bp.stall_accepts", 132'(stall_accepts), 132'(exp_stall_accepts));
        check("bp.sent", 132'(nsent), 132'(12));
        check("bp.leftover", 132'(sb_q.size()), 132'(0));
        check("bp.idle", 132'(bus.out_valid), 132'(0));

        // Reset while holding beats must discard them
        bus.out_ready = 1'b0;
        drive(1'b1, 128'h5, 128'h6, 4'd7);
        cyc();
        drive(1'b1, 128'h7, 128'h8, 4'd8);
        cyc();
        check("pre_rst.valid", 132'(bus.out_valid), 132'(1));
        rst = 1'b1;
        #1;
        check("mid_rst.valid", 132'(bus.out_valid), 132'(0));
        check("mid_rst.state", 132'(bus.out_state), 132'(0));
        check("mid_rst.err",   132'(bus.err_round), 132'(0));
        cyc();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b1, 128'h00112233445566778899aabbccddeeff,
                    128'h000102030405060708090a0b0c0d0e0f, 4'd5);
        cyc();
        check_out("post_rst", 128'h00102030405060708090a0b0c0d0e0f0, 4'd5, 1'b0);
        drive(1'b0, '0, '0, '0);
        cyc();
        check("post_rst.drain", 132'(bus.out_valid), 132'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
